fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Holds the program counter (PCF) and drives the instruction memory address.
- Captures the returned word into the IF/ID pipeline register.
- Obeys stall, flush and branch-redirect controls from the hazard unit and execute stage, and keeps a saturating count of instructions delivered to decode.

---
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : RV32I instruction fetch stage. Holds PCF, drives the instruction
//           memory address, and loads the IF/ID register. Keeps a saturating
//           count of instructions delivered to decode.
// Option  : FETCH_ALIGN_CHK_EN - word-align redirect targets and flag any
//           misaligned redirect in the sticky MisalignErr output.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [31:0]      PCTargetE,
  output logic [31:0]      Address,
  input  logic [31:0]      Instr_F,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] FetchCnt,
  output logic             MisalignErr
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pcf;
  logic [31:0]      r_instrd;
  logic [31:0]      r_pcd;
  logic [31:0]      r_pcplus4d;
  logic             r_validd;
  logic [CNT_W-1:0] r_fetchcnt;
  logic [31:0]      w_pcplus4f;
  logic [31:0]      w_target;
  logic             w_bubble;
  logic             w_load;

  assign w_pcplus4f = r_pcf + 32'd4;
  assign w_bubble   = FlushD | PCSrcE;
  assign w_load     = ~w_bubble & ~StallD;

`ifdef FETCH_ALIGN_CHK_EN
  logic r_misalign;

  assign w_target = {PCTargetE[31:2], 2'b00};

  // Sticky until reset; aligned redirects never clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign MisalignErr = r_misalign;
`else
  assign w_target    = PCTargetE;
  assign MisalignErr = 1'b0;
`endif

  // A redirect outranks StallF so a stalled front end cannot miss a branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf <= RESET_PC;
    end else if (PCSrcE) begin
      r_pcf <= w_target;
    end else if (!StallF) begin
      r_pcf <= w_pcplus4f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_instrd   <= 32'h0;
      r_pcd      <= 32'h0;
      r_pcplus4d <= 32'h0;
      r_validd   <= 1'b0;
    end else if (!StallD) begin
      r_instrd   <= Instr_F;
      r_pcd      <= r_pcf;
      r_pcplus4d <= w_pcplus4f;
      r_validd   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchcnt <= '0;
    end else if (w_load && (r_fetchcnt != {CNT_W{1'b1}})) begin
      r_fetchcnt <= r_fetchcnt + C_CNT_ONE;
    end
  end

  assign Address  = r_pcf;
  assign InstrD   = r_instrd;
  assign PCD      = r_pcd;
  assign PCPlus4D = r_pcplus4d;
  assign ValidD   = r_validd;
  assign FetchCnt = r_fetchcnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed self-checking bench for fetch_stage (default 16-bit
//           counter instance plus a 2-bit counter instance for saturation).
// Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] Address, Instr_F, InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignErr;
  logic [15:0] FetchCnt;
  logic [31:0] s_Address, s_Instr_F, s_InstrD, s_PCD, s_PCPlus4D;
  logic        s_ValidD, s_MisalignErr;
  logic [1:0]  s_FetchCnt;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem = 32'h0000_0000;
      32'h0000_0004: mem = 32'h00C4_8413;
      32'h0000_0008: mem = 32'hFF23_0913;
      32'h0000_000C: mem = 32'hFFA9_A383;
      32'h0000_0040: mem = 32'h0050_0093;
      default:       mem = 32'h0000_0013;
    endcase
  endfunction

  assign Instr_F   = mem(Address);
  assign s_Instr_F = mem(s_Address);

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .Address(Address), .Instr_F(Instr_F), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchCnt(FetchCnt),
    .MisalignErr(MisalignErr)
  );

  fetch_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .Address(s_Address), .Instr_F(s_Instr_F), .InstrD(s_InstrD), .PCD(s_PCD),
    .PCPlus4D(s_PCPlus4D), .ValidD(s_ValidD), .FetchCnt(s_FetchCnt),
    .MisalignErr(s_MisalignErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic sf, input logic sd, input logic fd,
                     input logic br, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = br; PCTargetE = tgt;
  endtask

  task automatic chk_d(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic v);
    chk({tag, "_InstrD"}, InstrD, ins);
    chk({tag, "_PCD"}, PCD, pc);
    chk({tag, "_PCPlus4D"}, PCPlus4D, pc4);
    chk({tag, "_ValidD"}, {31'b0, ValidD}, {31'b0, v});
  endtask

  initial begin
    reset = 1'b1;
    ctl(0, 0, 0, 0, 32'h0);
    step();
    step();
    chk("rst_Address", Address, 32'h0);
    chk_d("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst_FetchCnt", {16'b0, FetchCnt}, 32'd0);
    chk("rst_Misalign", {31'b0, MisalignErr}, 32'd0);

    // Free-running fetch; the zero word still counts as a valid instruction
    reset = 1'b0;
    step();
    chk("run1_Address", Address, 32'h4);
    chk_d("run1", 32'h0, 32'h0, 32'h4, 1'b1);
    chk("run1_FetchCnt", {16'b0, FetchCnt}, 32'd1);
    step();
    chk("run2_Address", Address, 32'h8);
    chk_d("run2", 32'h00C4_8413, 32'h4, 32'h8, 1'b1);
    chk("run2_FetchCnt", {16'b0, FetchCnt}, 32'd2);

    // Joint stall holds PCF and IF/ID
    ctl(1, 1, 0, 0, 32'h0);
    step();
    step();
    chk("stall_Address", Address, 32'h8);
    chk_d("stall", 32'h00C4_8413, 32'h4, 32'h8, 1'b1);
    chk("stall_FetchCnt", {16'b0, FetchCnt}, 32'd2);
    ctl(0, 0, 0, 0, 32'h0);
    step();
    chk("rel_Address", Address, 32'hC);
    chk_d("rel", 32'hFF23_0913, 32'h8, 32'hC, 1'b1);
    chk("rel_FetchCnt", {16'b0, FetchCnt}, 32'd3);
    step();
    chk_d("run4", 32'hFFA9_A383, 32'hC, 32'h10, 1'b1);
    chk("run4_FetchCnt", {16'b0, FetchCnt}, 32'd4);
    chk("sat_FetchCnt", {30'b0, s_FetchCnt}, 32'd3);

    // Redirect beats simultaneous stalls
    ctl(1, 1, 0, 1, 32'h40);
    step();
    chk("br_Address", Address, 32'h40);
    chk_d("br", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("br_FetchCnt", {16'b0, FetchCnt}, 32'd4);
    ctl(0, 0, 0, 0, 32'h0);
    step();
    chk("brt_Address", Address, 32'h44);
    chk_d("brt", 32'h0050_0093, 32'h40, 32'h44, 1'b1);
    chk("brt_FetchCnt", {16'b0, FetchCnt}, 32'd5);
    chk("sat_hold_FetchCnt", {30'b0, s_FetchCnt}, 32'd3);

    // Flush beats StallD; PC still advances since StallF is low
    ctl(0, 1, 1, 0, 32'h0);
    step();
    chk("fl_Address", Address, 32'h48);
    chk_d("fl", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("fl_FetchCnt", {16'b0, FetchCnt}, 32'd5);

    // PC wrap at top of address space
    ctl(0, 0, 0, 1, 32'hFFFF_FFFC);
    step();
    chk("wr_Address", Address, 32'hFFFF_FFFC);
    ctl(0, 0, 0, 0, 32'h0);
    step();
    chk("wr1_Address", Address, 32'h0);
    chk_d("wr1", 32'h0000_0013, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk("wr1_FetchCnt", {16'b0, FetchCnt}, 32'd6);
    step();
    chk("wr2_Address", Address, 32'h4);
    chk("wr2_FetchCnt", {16'b0, FetchCnt}, 32'd7);

    // Mid-run reset
    reset = 1'b1;
    step();
    chk("rst2_Address", Address, 32'h0);
    chk_d("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst2_FetchCnt", {16'b0, FetchCnt}, 32'd0);
    chk("rst2_sat_FetchCnt", {30'b0, s_FetchCnt}, 32'd0);
    reset = 1'b0;

    // Misaligned redirect handling
    ctl(0, 0, 0, 1, 32'h16);
    step();
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_Address", Address, 32'h14);
    chk("mis_Misalign", {31'b0, MisalignErr}, 32'd1);
`else
    chk("mis_Address", Address, 32'h16);
    chk("mis_Misalign", {31'b0, MisalignErr}, 32'd0);
`endif
    ctl(0, 0, 0, 1, 32'h20);
    step();
    chk("al_Address", Address, 32'h20);
`ifdef FETCH_ALIGN_CHK_EN
    chk("al_Misalign", {31'b0, MisalignErr}, 32'd1);
`else
    chk("al_Misalign", {31'b0, MisalignErr}, 32'd0);
`endif
    ctl(0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    step();
    chk("rst3_Misalign", {31'b0, MisalignErr}, 32'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
